sync_fifo_cntrl: RTL
====================

Name: sync_fifo_cntrl

Overview:
Single-clock, parametrised FIFO: storage array plus pointer/flag control in one block, replacing the bare memory-plus-external-pointer arrangement.
Used wherever producer and consumer share one clock domain (e.g. UART TX staging, register-file command queues).
Adds the following to plain storage:
- full/empty and almost-full/almost-empty flags
- occupancy count
- sticky overflow/underflow errors
- synchronous flush
- selectable standard or first-word-fall-through (FWFT) read mode

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 3, pointer address bits; depth = 2**ADDR_WIDTH
DATA_DEPTH, 8, number of entries; must equal 2**ADDR_WIDTH
AFULL_THRESH, 6, almost_full asserted when count >= AFULL_THRESH (range 1..DATA_DEPTH)
AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH (range 0..DATA_DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
wclk  input  1  clock; all state updates on rising edge
wrst_n  input  1  reset; asynchronous assert, active-low
flush  input  1  synchronous clear of FIFO contents/state
wr_en  input  1  write request
wdata  input  DATA_WIDTH  write data
rd_en  input  1  read request (FWFT=1: acknowledge/pop of head)
rdata  output  DATA_WIDTH  read data
rvalid  output  1  rdata valid qualifier
full  output  1  count == DATA_DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DATA_DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Pointers:
  - wptr/rptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - Address = low ADDR_WIDTH bits.
  - count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
  - full when the addresses are equal and the wrap bits differ; empty when the pointers are equal.
- Accept rules, evaluated on flag values before the edge:
  - Write accepted iff wr_en && !full: mem[wptr addr] <= wdata, wptr +1.
  - Read accepted iff rd_en && !empty: rptr +1.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read accepted, write rejected, overflow set.
  - Empty: write accepted, read rejected, underflow set.
- Wrap-around: pointer increments roll naturally; entry DATA_DEPTH-1 is followed by entry 0.
- Flags and count: all registered or derived from registered pointers; they update in the cycle after the accepted operation.
- FWFT=0:
  - On an accepted read, rdata <= mem[rptr addr] at the same edge, so data appears 1 cycle after rd_en.
  - rvalid pulses high for exactly that one cycle.
  - rdata otherwise holds its last value.
- FWFT=1:
  - rdata = mem[rptr addr] (combinational from storage); rvalid = !empty.
  - A word written into an empty FIFO is visible on rdata, with rvalid=1, in the cycle after the write edge.
  - rd_en pops the head; the next word is presented the following cycle.
- overflow / underflow:
  - Set on a rejected write / rejected read respectively.
  - Remain 1 until flush or reset; never cleared by normal traffic.
- flush:
  - At the edge: wptr=rptr=0, overflow=underflow=0, rvalid=0.
  - Flags return to empty state; storage contents are not cleared.
  - flush has priority over wr_en/rd_en in the same cycle: both are ignored, no error flag is set.
  - FWFT=0: rdata holds.
- Reset (wrst_n=0, asynchronous, any time including mid-burst):
  - All storage entries = 0, pointers = 0, rdata = 0, rvalid = 0.
  - full = 0, empty = 1, almost_empty = 1, almost_full = 0, count = 0, overflow = 0, underflow = 0.
  - Release is synchronous to wclk; the first operation is accepted on the first edge after deassertion.
- Parameter check: a simulation-time error is raised if DATA_DEPTH != 2**ADDR_WIDTH, or if either threshold is out of range.

Test Plan:
1. Reset, then write 8 words 0x10..0x17 (FWFT=0) -> after 8th write: full=1, count=8, almost_full=1; then 9th write 0xAA -> overflow=1, count stays 8, memory unchanged.
2. Read 8 times from full FIFO (FWFT=0) -> rdata 0x10..0x17 each 1 cycle after rd_en, rvalid pulses each time, empty=1 after last; extra rd_en -> underflow=1, rdata holds 0x17.
3. Fill 5 words, read 3, write 6 more (wrap) -> count steps 5->2->8, reads return words in write order across pointer wrap, full=1 at count 8.
4. Count=4, wr_en=rd_en=1 for 10 cycles with incrementing data -> count stays 4, no error flags, output order preserved; repeat at full -> read accepted, write rejected, overflow=1.
5. FWFT=1: write 0x5A into empty FIFO -> next cycle rdata=0x5A, rvalid=1 without rd_en; rd_en -> following cycle empty=1, rvalid=0.
6. Mid-burst with overflow=1: assert flush together with wr_en -> count=0, empty=1, overflow=0, write ignored; then assert wrst_n=0 asynchronously mid-write -> all outputs at reset values immediately, not waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_cntrl.sv
// rtl/sync_fifo_cntrl.sv - single-clock FIFO with flags, count, sticky errors, flush and optional FWFT read
module sync_fifo_cntrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int DATA_DEPTH    = 8,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  if (DATA_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sync_fifo_cntrl: DATA_DEPTH must equal 2**ADDR_WIDTH");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DATA_DEPTH) begin : g_bad_afull
    $error("sync_fifo_cntrl: AFULL_THRESH out of range 1..DATA_DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DATA_DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_cntrl: AEMPTY_THRESH out of range 0..DATA_DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign waddr        = wptr[ADDR_WIDTH-1:0];
  assign raddr        = rptr[ADDR_WIDTH-1:0];
  assign count        = wptr - rptr;
  assign empty        = (wptr == rptr);
  assign full         = (waddr == raddr) && (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // flush wins over traffic: nothing is accepted and no error is recorded
  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < DATA_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_acc) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // head of queue is always presented; rd_en only pops it
    assign rdata  = mem[raddr];
    assign rvalid = !empty;
  end else begin : g_std
    always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
        rdata  <= '0;
        rvalid <= 1'b0;
      end else if (flush) begin
        rvalid <= 1'b0;
      end else begin
        rvalid <= rd_acc;
        if (rd_acc) rdata <= mem[raddr];
      end
    end
  end

endmodule
